// File: rtl/fence_responder_if.sv
// Fence bus bundle: backend sfence.vma / fence.i requests and the memory-side
// TLB and ICache flush handshakes, plus the responder busy flag.
interface fence_responder_if #(
  parameter int VADDR_SIZE = 39,
  parameter int ASID_W     = 16,
  parameter int TLB_NUM    = 3
);
  logic                  mmu_flush;
  logic                  mmu_flush_all;
  logic [VADDR_SIZE-1:0] vma_vaddr;
  logic [ASID_W-1:0]     vma_asid;
  logic                  mmu_flush_end;
  logic                  inst_flush;
  logic                  inst_flush_end;
  logic [TLB_NUM-1:0]    tlb_flush_valid;
  logic [TLB_NUM-1:0]    tlb_flush_ack;
  logic                  tlb_flush_all;
  logic [VADDR_SIZE-1:0] tlb_flush_vaddr;
  logic [ASID_W-1:0]     tlb_flush_asid;
  logic                  icache_flush_req;
  logic                  icache_flush_done;
  logic                  busy;

  // Responder view.
  modport slave (
    input  mmu_flush, mmu_flush_all, vma_vaddr, vma_asid, inst_flush,
           tlb_flush_ack, icache_flush_done,
    output mmu_flush_end, inst_flush_end, tlb_flush_valid, tlb_flush_all,
           tlb_flush_vaddr, tlb_flush_asid, icache_flush_req, busy
  );

  // Backend plus memory-side view.
  modport master (
    output mmu_flush, mmu_flush_all, vma_vaddr, vma_asid, inst_flush,
           tlb_flush_ack, icache_flush_done,
    input  mmu_flush_end, inst_flush_end, tlb_flush_valid, tlb_flush_all,
           tlb_flush_vaddr, tlb_flush_asid, icache_flush_req, busy
  );
endinterface

// File: rtl/fence_responder.sv
// Fence responder: fans sfence.vma out to the TLBs and fence.i to the ICache,
// collects acknowledgements and returns one-cycle completion pulses.
module fence_responder #(
  parameter int VADDR_SIZE = 39,
  parameter int ASID_W     = 16,
  parameter int TLB_NUM    = 3
) (
  input  logic             clk,
  input  logic             rst,
  fence_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MMU_WAIT,
    MMU_END,
    IC_WAIT,
    IC_END
  } state_e;

  state_e                state_q,      state_d;
  logic [TLB_NUM-1:0]    valid_q,      valid_d;
  logic                  bc_all_q,     bc_all_d;
  logic [VADDR_SIZE-1:0] bc_vaddr_q,   bc_vaddr_d;
  logic [ASID_W-1:0]     bc_asid_q,    bc_asid_d;
  logic                  mmu_pend_q,   mmu_pend_d;
  logic                  pend_all_q,   pend_all_d;
  logic [VADDR_SIZE-1:0] pend_vaddr_q, pend_vaddr_d;
  logic [ASID_W-1:0]     pend_asid_q,  pend_asid_d;
  logic                  ic_pend_q,    ic_pend_d;
  logic                  ic_req_q,     ic_req_d;
  logic                  mmu_end_q,    mmu_end_d;
  logic                  ic_end_q,     ic_end_d;
  logic                  busy_q,       busy_d;

  logic mmu_cand;
  logic ic_direct;

  // MMU work always wins IDLE; fence.i is served directly only when none is present.
  assign mmu_cand  = bus.mmu_flush | mmu_pend_q;
  assign ic_direct = (state_q == IDLE) && !mmu_cand;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which is what keeps this block free of inferred latches.
    state_d      = state_q;
    valid_d      = valid_q;
    bc_all_d     = bc_all_q;
    bc_vaddr_d   = bc_vaddr_q;
    bc_asid_d    = bc_asid_q;
    mmu_pend_d   = mmu_pend_q;
    pend_all_d   = pend_all_q;
    pend_vaddr_d = pend_vaddr_q;
    pend_asid_d  = pend_asid_q;
    ic_pend_d    = ic_pend_q;
    ic_req_d     = ic_req_q;
    mmu_end_d    = 1'b0;
    ic_end_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.mmu_flush) begin
          // A live request is broadcast as-is; any pending op stays queued.
          bc_all_d   = bus.mmu_flush_all;
          bc_vaddr_d = bus.vma_vaddr;
          bc_asid_d  = bus.vma_asid;
          valid_d    = '1;
          state_d    = MMU_WAIT;
        end else if (mmu_pend_q) begin
          bc_all_d   = pend_all_q;
          bc_vaddr_d = pend_vaddr_q;
          bc_asid_d  = pend_asid_q;
          mmu_pend_d = 1'b0;
          valid_d    = '1;
          state_d    = MMU_WAIT;
        end else if (bus.inst_flush || ic_pend_q) begin
          ic_pend_d = 1'b0;
          ic_req_d  = 1'b1;
          state_d   = IC_WAIT;
        end
      end
      MMU_WAIT: begin
        valid_d = valid_q & ~bus.tlb_flush_ack;
        if (valid_d == '0) begin
          mmu_end_d = 1'b1;
          state_d   = MMU_END;
        end
      end
      MMU_END: state_d = IDLE;
      IC_WAIT: begin
        if (bus.icache_flush_done) begin
          ic_req_d = 1'b0;
          ic_end_d = 1'b1;
          state_d  = IC_END;
        end
      end
      IC_END:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A second differing request while one is already queued degrades the
    // queued op to flush-all so neither target is lost.
    if (bus.mmu_flush && (state_q != IDLE)) begin
      mmu_pend_d = 1'b1;
      if (!mmu_pend_q) begin
        pend_all_d   = bus.mmu_flush_all;
        pend_vaddr_d = bus.vma_vaddr;
        pend_asid_d  = bus.vma_asid;
      end else begin
        pend_all_d = pend_all_q | bus.mmu_flush_all |
                     (bus.vma_vaddr != pend_vaddr_q) |
                     (bus.vma_asid != pend_asid_q);
      end
    end

    if (bus.inst_flush && !ic_direct) begin
      ic_pend_d = 1'b1;
    end

    busy_d = (state_d != IDLE) | mmu_pend_d | ic_pend_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      bc_all_q     <= 1'b0;
      bc_vaddr_q   <= '0;
      bc_asid_q    <= '0;
      mmu_pend_q   <= 1'b0;
      pend_all_q   <= 1'b0;
      pend_vaddr_q <= '0;
      pend_asid_q  <= '0;
      ic_pend_q    <= 1'b0;
      ic_req_q     <= 1'b0;
      mmu_end_q    <= 1'b0;
      ic_end_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      bc_all_q     <= bc_all_d;
      bc_vaddr_q   <= bc_vaddr_d;
      bc_asid_q    <= bc_asid_d;
      mmu_pend_q   <= mmu_pend_d;
      pend_all_q   <= pend_all_d;
      pend_vaddr_q <= pend_vaddr_d;
      pend_asid_q  <= pend_asid_d;
      ic_pend_q    <= ic_pend_d;
      ic_req_q     <= ic_req_d;
      mmu_end_q    <= mmu_end_d;
      ic_end_q     <= ic_end_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.tlb_flush_valid  = valid_q;
  assign bus.tlb_flush_all    = bc_all_q;
  assign bus.tlb_flush_vaddr  = bc_vaddr_q;
  assign bus.tlb_flush_asid   = bc_asid_q;
  assign bus.icache_flush_req = ic_req_q;
  assign bus.mmu_flush_end    = mmu_end_q;
  assign bus.inst_flush_end   = ic_end_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_fence_responder.sv
// Self-checking bench for fence_responder: directed vector table, hand-written
// merge/reset sequences, then random traffic against a transaction-level model.
module tb_fence_responder;
  localparam int VA = 39;
  localparam int AW = 16;
  localparam int TN = 3;

  logic clk;
  logic rst;

  fence_responder_if #(.VADDR_SIZE(VA), .ASID_W(AW), .TLB_NUM(TN)) bus ();

  fence_responder #(.VADDR_SIZE(VA), .ASID_W(AW), .TLB_NUM(TN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic m, input logic a, input logic [VA-1:0] va,
                       input logic [AW-1:0] as, input logic i,
                       input logic [TN-1:0] ack, input logic done);
    bus.mmu_flush         = m;
    bus.mmu_flush_all     = a;
    bus.vma_vaddr         = va;
    bus.vma_asid          = as;
    bus.inst_flush        = i;
    bus.tlb_flush_ack     = ack;
    bus.icache_flush_done = done;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   64'(bus.tlb_flush_valid),  64'd0);
    check({tag, "_all"},     64'(bus.tlb_flush_all),    64'd0);
    check({tag, "_vaddr"},   64'(bus.tlb_flush_vaddr),  64'd0);
    check({tag, "_asid"},    64'(bus.tlb_flush_asid),   64'd0);
    check({tag, "_icreq"},   64'(bus.icache_flush_req), 64'd0);
    check({tag, "_mmu_end"}, 64'(bus.mmu_flush_end),    64'd0);
    check({tag, "_ic_end"},  64'(bus.inst_flush_end),   64'd0);
    check({tag, "_busy"},    64'(bus.busy),             64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          mmu;
    logic          all;
    logic [VA-1:0] vaddr;
    logic [AW-1:0] asid;
    logic          inst;
    logic [TN-1:0] ack;
    logic          done;
    logic [TN-1:0] e_valid;
    logic          e_mend;
    logic          e_icreq;
    logic          e_icend;
    logic          e_busy;
  } vec_t;

  vec_t          vecs[$];
  logic          seq_all;
  logic [VA-1:0] seq_vaddr;
  logic [AW-1:0] seq_asid;

  // Qualifiers come from the current sequence's op; expected broadcast is the same.
  task automatic add(input logic m, input logic i, input logic [TN-1:0] ack,
                     input logic done, input logic [TN-1:0] ev, input logic em,
                     input logic eir, input logic eie, input logic eb);
    vec_t v;
    v.mmu = m; v.all = seq_all; v.vaddr = seq_vaddr; v.asid = seq_asid;
    v.inst = i; v.ack = ack; v.done = done;
    v.e_valid = ev; v.e_mend = em; v.e_icreq = eir; v.e_icend = eie; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  // ---------------- random-phase model state ----------------
  typedef struct {
    int            cyc;
    logic          all;
    logic [VA-1:0] vaddr;
    logic [AW-1:0] asid;
  } mreq_t;

  mreq_t         mq[$];
  int            iq[$];
  logic [TN-1:0] prev_valid, prev_ack;
  logic          prev_icreq, prev_done;
  logic          op_all;
  logic [VA-1:0] op_vaddr;
  logic [AW-1:0] op_asid;
  int            mmu_ops, mmu_ends, ic_ops, ic_ends;

  initial begin
    logic [VA-1:0] va_set [4];
    logic [AW-1:0] as_set [2];
    int            cnt;
    int            starts;
    logic          first_all, second_all;
    logic [VA-1:0] first_vaddr;

    va_set[0] = 39'h00_0000_1000; va_set[1] = 39'h00_0000_2000;
    va_set[2] = 39'h7f_ffff_f000; va_set[3] = 39'h0;
    as_set[0] = 16'd5;            as_set[1] = 16'hffff;

    // ---- reset then idle ----
    drive(0, 0, '0, '0, 0, '0, 0);
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();
    check_all_zero("reset");
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.mmu_flush_end || bus.inst_flush_end || bus.busy || bus.tlb_flush_valid != '0) cnt++;
    end
    check("idle_spurious", 64'(cnt), 64'd0);

    // ---- table: single sfence with acks tied high ----
    seq_all = 1'b0; seq_vaddr = 39'h1000; seq_asid = 16'd5;
    add(1, 0, 3'b111, 0, 3'b111, 0, 0, 0, 1);
    add(0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 1);
    add(0, 0, 3'b111, 0, 3'b000, 0, 0, 0, 0);
    add(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
    // ---- staggered acks: ITLB, then L2, then DTLB; stale ITLB ack ignored ----
    seq_all = 1'b1; seq_vaddr = 39'h4000; seq_asid = 16'd7;
    add(1, 0, 3'b000, 0, 3'b111, 0, 0, 0, 1);
    add(0, 0, 3'b001, 0, 3'b110, 0, 0, 0, 1);
    add(0, 0, 3'b000, 0, 3'b110, 0, 0, 0, 1);
    add(0, 0, 3'b000, 0, 3'b110, 0, 0, 0, 1);
    add(0, 0, 3'b100, 0, 3'b010, 0, 0, 0, 1);
    add(0, 0, 3'b001, 0, 3'b010, 0, 0, 0, 1);
    add(0, 0, 3'b000, 0, 3'b010, 0, 0, 0, 1);
    add(0, 0, 3'b010, 0, 3'b000, 1, 0, 0, 1);
    add(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
    // ---- collision: MMU first, IC picked up from pending ----
    seq_all = 1'b0; seq_vaddr = 39'h5000; seq_asid = 16'd3;
    add(1, 1, 3'b000, 0, 3'b111, 0, 0, 0, 1);
    add(0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 1);
    add(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 1);
    add(0, 0, 3'b000, 0, 3'b000, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) add(0, 0, 3'b000, 0, 3'b000, 0, 1, 0, 1);
    add(0, 0, 3'b000, 1, 3'b000, 0, 0, 1, 1);
    add(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].mmu, vecs[i].all, vecs[i].vaddr, vecs[i].asid,
            vecs[i].inst, vecs[i].ack, vecs[i].done);
      step();
      check($sformatf("vec%0d_valid", i),   64'(bus.tlb_flush_valid),  64'(vecs[i].e_valid));
      check($sformatf("vec%0d_mmu_end", i), 64'(bus.mmu_flush_end),    64'(vecs[i].e_mend));
      check($sformatf("vec%0d_icreq", i),   64'(bus.icache_flush_req), 64'(vecs[i].e_icreq));
      check($sformatf("vec%0d_ic_end", i),  64'(bus.inst_flush_end),   64'(vecs[i].e_icend));
      check($sformatf("vec%0d_busy", i),    64'(bus.busy),             64'(vecs[i].e_busy));
      if (vecs[i].e_valid != '0) begin
        check($sformatf("vec%0d_bc_all", i),   64'(bus.tlb_flush_all),   64'(vecs[i].all));
        check($sformatf("vec%0d_bc_vaddr", i), 64'(bus.tlb_flush_vaddr), 64'(vecs[i].vaddr));
        check($sformatf("vec%0d_bc_asid", i),  64'(bus.tlb_flush_asid),  64'(vecs[i].asid));
      end
    end

    // ---- merge: two differing requests during MMU_WAIT ----
    cnt = 0; starts = 0;
    first_all = 1'b1; second_all = 1'b0; first_vaddr = '0;
    prev_valid = '0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0)      drive(1, 0, 39'h1000, 16'd5, 0, 3'b000, 0);
      else if (k == 1) drive(1, 0, 39'h2000, 16'd5, 0, 3'b000, 0);
      else if (k == 2) drive(1, 0, 39'h3000, 16'd5, 0, 3'b000, 0);
      else if (k == 3) drive(0, 0, '0, '0, 0, 3'b000, 0);
      else             drive(0, 0, '0, '0, 0, 3'b111, 0);
      prev_valid = bus.tlb_flush_valid;
      step();
      if (prev_valid == '0 && bus.tlb_flush_valid != '0) begin
        starts++;
        if (starts == 1) begin first_all = bus.tlb_flush_all; first_vaddr = bus.tlb_flush_vaddr; end
        if (starts == 2) second_all = bus.tlb_flush_all;
      end
      if (bus.mmu_flush_end) cnt++;
    end
    check("merge_end_pulses", 64'(cnt), 64'd2);
    check("merge_ops",        64'(starts), 64'd2);
    check("merge_op1_all",    64'(first_all), 64'd0);
    check("merge_op1_vaddr",  64'(first_vaddr), 64'h1000);
    check("merge_op2_all",    64'(second_all), 64'd1);
    check("merge_idle_busy",  64'(bus.busy), 64'd0);

    // ---- reset during IC_WAIT ----
    drive(0, 0, '0, '0, 1, '0, 0);
    step();
    drive(0, 0, '0, '0, 0, '0, 0);
    check("rstmid_icreq_before", 64'(bus.icache_flush_req), 64'd1);
    step();
    rst = 1'b1;
    step();
    check("rstmid_icreq", 64'(bus.icache_flush_req), 64'd0);
    check("rstmid_busy",  64'(bus.busy), 64'd0);
    rst = 1'b0;
    drive(0, 0, '0, '0, 0, '0, 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.inst_flush_end || bus.icache_flush_req) cnt++;
    end
    check("rstmid_no_ic_end", 64'(cnt), 64'd0);

    // ---- random traffic vs transaction-level model ----
    mmu_ops = 0; mmu_ends = 0; ic_ops = 0; ic_ends = 0;
    op_all = 1'b0; op_vaddr = '0; op_asid = '0;
    for (int c = 0; c < 3000; c++) begin
      logic          m, a, in, dn;
      logic [TN-1:0] ak;
      logic [VA-1:0] va;
      logic [AW-1:0] as;
      logic [TN-1:0] cv;
      mreq_t         r;
      mreq_t         keep[$];
      int            ikeep[$];

      if (c < 2900) begin
        m  = ($urandom_range(7) == 0);
        in = ($urandom_range(7) == 0);
        for (int b = 0; b < TN; b++) ak[b] = ($urandom_range(2) == 0);
        dn = ($urandom_range(3) == 0);
      end else begin
        m = 1'b0; in = 1'b0; ak = '1; dn = 1'b1;
      end
      a  = ($urandom_range(3) == 0);
      va = va_set[$urandom_range(3)];
      as = as_set[$urandom_range(1)];
      drive(m, a, va, as, in, ak, dn);
      if (m) begin r.cyc = c; r.all = a; r.vaddr = va; r.asid = as; mq.push_back(r); end
      if (in) iq.push_back(c);
      prev_valid = bus.tlb_flush_valid;
      prev_icreq = bus.icache_flush_req;
      prev_ack   = ak;
      prev_done  = dn;
      step();

      cv = bus.tlb_flush_valid;
      if (prev_valid == '0 && cv != '0) begin
        mmu_ops++;
        check("rnd_start_valid", 64'(cv), 64'(3'b111));
        op_all = bus.tlb_flush_all; op_vaddr = bus.tlb_flush_vaddr; op_asid = bus.tlb_flush_asid;
        keep = {};
        foreach (mq[j])
          if (!(mq[j].cyc <= c &&
                (op_all || (!mq[j].all && mq[j].vaddr == op_vaddr && mq[j].asid == op_asid))))
            keep.push_back(mq[j]);
        mq = keep;
      end
      if (prev_valid != '0) begin
        check("rnd_valid_clear", 64'(cv), 64'(prev_valid & ~prev_ack));
        if (cv != '0)
          check("rnd_bc_stable", {24'd0, op_all, op_vaddr},
                {24'd0, bus.tlb_flush_all, bus.tlb_flush_vaddr});
        if (cv == '0) check("rnd_mmu_end_due", 64'(bus.mmu_flush_end), 64'd1);
      end
      if (bus.mmu_flush_end) begin
        mmu_ends++;
        check("rnd_mmu_end_cause", 64'(prev_valid != '0 && cv == '0), 64'd1);
      end
      if (!prev_icreq && bus.icache_flush_req) begin
        ic_ops++;
        ikeep = {};
        foreach (iq[j]) if (iq[j] > c) ikeep.push_back(iq[j]);
        iq = ikeep;
      end
      if (prev_icreq && !bus.icache_flush_req) begin
        check("rnd_ic_fall_done", 64'(prev_done), 64'd1);
        check("rnd_ic_end_due",   64'(bus.inst_flush_end), 64'd1);
      end
      if (bus.inst_flush_end) begin
        ic_ends++;
        check("rnd_ic_end_cause", 64'(prev_icreq && !bus.icache_flush_req), 64'd1);
      end
      if (cv != '0) check("rnd_exclusive", 64'(bus.icache_flush_req), 64'd0);
      if (cv != '0 || bus.icache_flush_req) check("rnd_busy_active", 64'(bus.busy), 64'd1);
      if (!bus.busy) check("rnd_idle_nothing_owed", 64'(mq.size() + iq.size()), 64'd0);
    end
    check("rnd_mmu_unserved",  64'(mq.size()), 64'd0);
    check("rnd_ic_unserved",   64'(iq.size()), 64'd0);
    check("rnd_mmu_end_count", 64'(mmu_ends), 64'(mmu_ops));
    check("rnd_ic_end_count",  64'(ic_ends),  64'(ic_ops));
    check("rnd_mmu_activity",  64'(mmu_ops > 10), 64'd1);
    check("rnd_ic_activity",   64'(ic_ops > 10),  64'd1);
    check("rnd_final_busy",    64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
